// File: rtl/commit_trace_pipe_pkg.sv
// Shared definitions for the commit trace pipeline.
// Holds the default field widths, the trace entry layout at those widths,
// the bubble value and the "no op" encoding.
package commit_trace_pipe_pkg;

  localparam int unsigned OpWDefault   = 12;
  localparam int unsigned InstWDefault = 32;
  localparam int unsigned PcWDefault   = 64;
  localparam int unsigned CntWDefault  = 64;

  // An all-ones op marks an empty slot so invalid stages never alias a real op.
  localparam logic [OpWDefault-1:0] OP_NONE = '1;

  typedef struct packed {
    logic                    valid;
    logic                    ebreak;
    logic [OpWDefault-1:0]   op;
    logic [InstWDefault-1:0] inst;
    logic [PcWDefault-1:0]   pc;
  } trace_entry_t;

  localparam trace_entry_t BUBBLE = '{
    valid:  1'b0,
    ebreak: 1'b0,
    op:     OP_NONE,
    inst:   '0,
    pc:     '0
  };

endpackage

// File: rtl/commit_trace_pipe_trace_stage.sv
// One entry register of the commit trace pipeline.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   load_i            capture the input entry (bubble if in_valid_i is low)
//   kill_i            replace the entry with a bubble (wins over load_i)
//   in_*_i            incoming entry fields
//   q_*_o             registered entry fields
// With neither load_i nor kill_i asserted the entry holds.
module commit_trace_pipe_trace_stage
  import commit_trace_pipe_pkg::*;
#(
  parameter int unsigned OP_W   = OpWDefault,
  parameter int unsigned INST_W = InstWDefault,
  parameter int unsigned PC_W   = PcWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              kill_i,
  input  logic              in_valid_i,
  input  logic              in_ebreak_i,
  input  logic [OP_W-1:0]   in_op_i,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic [PC_W-1:0]   in_pc_i,
  output logic              q_valid_o,
  output logic              q_ebreak_o,
  output logic [OP_W-1:0]   q_op_o,
  output logic [INST_W-1:0] q_inst_o,
  output logic [PC_W-1:0]   q_pc_o
);

  logic              valid_q, valid_d;
  logic              ebreak_q, ebreak_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  always_comb begin
    valid_d  = valid_q;
    ebreak_d = ebreak_q;
    op_d     = op_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    if (kill_i || (load_i && !in_valid_i)) begin
      // Invalid loads carry a fixed payload so the trace never shows stale data.
      valid_d  = 1'b0;
      ebreak_d = 1'b0;
      op_d     = '1;
      inst_d   = '0;
      pc_d     = '0;
    end else if (load_i) begin
      valid_d  = 1'b1;
      ebreak_d = in_ebreak_i;
      op_d     = in_op_i;
      inst_d   = in_inst_i;
      pc_d     = in_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ebreak_q <= 1'b0;
      op_q     <= '1;
      inst_q   <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ebreak_q <= ebreak_d;
      op_q     <= op_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
    end
  end

  assign q_valid_o  = valid_q;
  assign q_ebreak_o = ebreak_q;
  assign q_op_o     = op_q;
  assign q_inst_o   = inst_q;
  assign q_pc_o     = pc_q;

endmodule

// File: rtl/commit_trace_pipe.sv
// Commit trace pipeline: delays retiring-instruction trace data from writeback
// by DEPTH register stages so it lines up with architectural commit.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   stall_i                       hold all stages, halt and counter
//   flush_i                       turn every stage into a bubble, drop the input
//   in_valid_i, in_ebreak_i,
//   in_op_i, in_inst_i, in_pc_i   retiring instruction from writeback
//   out_*_o                       last stage (the committing instruction)
//   halt_o                        sticky, set when an ebreak retires
//   retire_cnt_o                  number of retire events, wraps
module commit_trace_pipe
  import commit_trace_pipe_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned OP_W   = OpWDefault,
  parameter int unsigned INST_W = InstWDefault,
  parameter int unsigned PC_W   = PcWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic              in_ebreak_i,
  input  logic [OP_W-1:0]   in_op_i,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic [PC_W-1:0]   in_pc_i,
  output logic              out_valid_o,
  output logic              out_ebreak_o,
  output logic [OP_W-1:0]   out_op_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic              halt_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic [DEPTH-1:0]  stg_valid;
  logic [DEPTH-1:0]  stg_ebreak;
  logic [OP_W-1:0]   stg_op   [DEPTH];
  logic [INST_W-1:0] stg_inst [DEPTH];
  logic [PC_W-1:0]   stg_pc   [DEPTH];

  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stage_load;
  logic             stage_kill;
  logic             retire;

  // Flush beats stall: a stalled pipeline is still emptied by a flush.
  assign stage_kill = flush_i;
  assign stage_load = !flush_i && !stall_i;

  for (genvar g = 0; g < DEPTH; g++) begin : gen_stage
    if (g == 0) begin : gen_head
      commit_trace_pipe_trace_stage #(
        .OP_W  (OP_W),
        .INST_W(INST_W),
        .PC_W  (PC_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .load_i     (stage_load),
        .kill_i     (stage_kill),
        // Once halted, new instructions are admitted only as bubbles.
        .in_valid_i (in_valid_i && !halt_q),
        .in_ebreak_i(in_ebreak_i),
        .in_op_i    (in_op_i),
        .in_inst_i  (in_inst_i),
        .in_pc_i    (in_pc_i),
        .q_valid_o  (stg_valid[g]),
        .q_ebreak_o (stg_ebreak[g]),
        .q_op_o     (stg_op[g]),
        .q_inst_o   (stg_inst[g]),
        .q_pc_o     (stg_pc[g])
      );
    end else begin : gen_body
      commit_trace_pipe_trace_stage #(
        .OP_W  (OP_W),
        .INST_W(INST_W),
        .PC_W  (PC_W)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .load_i     (stage_load),
        .kill_i     (stage_kill),
        .in_valid_i (stg_valid[g-1]),
        .in_ebreak_i(stg_ebreak[g-1]),
        .in_op_i    (stg_op[g-1]),
        .in_inst_i  (stg_inst[g-1]),
        .in_pc_i    (stg_pc[g-1]),
        .q_valid_o  (stg_valid[g]),
        .q_ebreak_o (stg_ebreak[g]),
        .q_op_o     (stg_op[g]),
        .q_inst_o   (stg_inst[g]),
        .q_pc_o     (stg_pc[g])
      );
    end
  end

  assign out_valid_o  = stg_valid[DEPTH-1];
  assign out_ebreak_o = stg_ebreak[DEPTH-1];
  assign out_op_o     = stg_op[DEPTH-1];
  assign out_inst_o   = stg_inst[DEPTH-1];
  assign out_pc_o     = stg_pc[DEPTH-1];

  // The last stage commits on any edge where it actually moves on.
  assign retire = stg_valid[DEPTH-1] && !stall_i && !flush_i;

  always_comb begin
    halt_d = halt_q;
    cnt_d  = cnt_q;
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (stg_ebreak[DEPTH-1]) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      halt_q <= halt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign halt_o       = halt_q;
  assign retire_cnt_o = cnt_q;

endmodule
